// File: rtl/map_pkg.sv
// Shared collision-map definitions: default grid dimensions, writer FSM encoding
// and the {row, column} address packing that the collision reader also uses.
package map_pkg;

  localparam int MAP_XW_DEF = 5;
  localparam int MAP_YW_DEF = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Row occupies the upper bits and column the lower xw bits; the caller keeps
  // the low (row width + xw) bits of the result.
  function automatic logic [31:0] pack_addr(input logic [15:0] row,
                                            input logic [15:0] col,
                                            input int          xw);
    return ({16'd0, row} << xw) | {16'd0, col};
  endfunction

endpackage

// File: rtl/map_rect_scan.sv
// Column-fastest raster counter over an inclusive rectangle; bounds are
// captured on start, last flags the final (y1, x1) cell.
module map_rect_scan #(
  parameter int XW = 5,
  parameter int YW = 5
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          step,
  input  logic [XW-1:0] x0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y0,
  input  logic [YW-1:0] y1,
  output logic [XW-1:0] col,
  output logic [YW-1:0] row,
  output logic          last
);

  logic [XW-1:0] x0_q;
  logic [XW-1:0] x1_q;
  logic [YW-1:0] y1_q;

  // NOTE: reset is synchronous (sampled on the clock edge), so it sits inside the
  // clocked branch rather than in the sensitivity list.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      x0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
      col  <= '0;
      row  <= '0;
    end else if (start) begin
      x0_q <= x0;
      x1_q <= x1;
      y1_q <= y1;
      col  <= x0;
      row  <= y0;
    end else if (step) begin
      if (col == x1_q) begin
        col <= x0_q;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Termination is by comparison, never by overflow, so a bound of the maximum
  // index ends the scan cleanly.
  assign last = (col == x1_q) && (row == y1_q);

endmodule

// File: rtl/block_map_writer.sv
// Collision-map rectangle filler: one write per cycle over an accepted rectangle.
// Optional macro BLOCK_MAP_WRITER_CLEAR_EN adds clr_req for a full-map clear to 0.
module block_map_writer
  import map_pkg::*;
#(
  parameter int MAP_XW = MAP_XW_DEF,
  parameter int MAP_YW = MAP_YW_DEF
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [MAP_XW-1:0]        cmd_x0,
  input  logic [MAP_XW-1:0]        cmd_x1,
  input  logic [MAP_YW-1:0]        cmd_y0,
  input  logic [MAP_YW-1:0]        cmd_y1,
  input  logic                     cmd_val,
`ifdef BLOCK_MAP_WRITER_CLEAR_EN
  input  logic                     clr_req,
`endif
  output logic                     we,
  output logic [MAP_YW+MAP_XW-1:0] waddr,
  output logic                     wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int AW = MAP_YW + MAP_XW;

  logic [1:0]        state;
  logic              val_q;
  logic              err_q;
  logic              cmd_fire;
  logic              cmd_ok;
  logic              start;
  logic              start_val;
  logic              last;
  logic [MAP_XW-1:0] sx0, sx1, col;
  logic [MAP_YW-1:0] sy0, sy1, row;
  logic [31:0]       addr_full;
  logic              unused_addr_hi;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign cmd_ok   = (cmd_x1 >= cmd_x0) && (cmd_y1 >= cmd_y0);

`ifdef BLOCK_MAP_WRITER_CLEAR_EN
  logic clr_fire;

  // A clear wins over a simultaneous command, which stays pending because
  // cmd_ready is withheld in that cycle.
  assign clr_fire  = (state == ST_IDLE) && clr_req;
  assign cmd_ready = rst_n && (state == ST_IDLE) && !clr_req;
  assign start     = clr_fire || (cmd_fire && cmd_ok);
  assign start_val = clr_fire ? 1'b0 : cmd_val;
  assign sx0       = clr_fire ? '0 : cmd_x0;
  assign sx1       = clr_fire ? '1 : cmd_x1;
  assign sy0       = clr_fire ? '0 : cmd_y0;
  assign sy1       = clr_fire ? '1 : cmd_y1;
`else
  assign cmd_ready = rst_n && (state == ST_IDLE);
  assign start     = cmd_fire && cmd_ok;
  assign start_val = cmd_val;
  assign sx0       = cmd_x0;
  assign sx1       = cmd_x1;
  assign sy0       = cmd_y0;
  assign sy1       = cmd_y1;
`endif

  map_rect_scan #(
    .XW (MAP_XW),
    .YW (MAP_YW)
  ) u_scan (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .start   (start),
    .step    ((state == ST_FILL) && !last),
    .x0      (sx0),
    .x1      (sx1),
    .y0      (sy0),
    .y1      (sy1),
    .col     (col),
    .row     (row),
    .last    (last)
  );

  // NOTE: all state updates use non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      val_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= cmd_fire && !cmd_ok;
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_FILL;
          val_q <= start_val;
        end
        ST_FILL: if (last) state <= ST_FIN;
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign addr_full      = pack_addr(16'(row), 16'(col), MAP_XW);
  assign waddr          = addr_full[AW-1:0];
  assign unused_addr_hi = ^addr_full[31:AW];

  assign we    = (state == ST_FILL);
  assign wdata = we && val_q;
  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_FIN);
  assign err   = err_q;

endmodule
